// File: rtl/leg_solver_if.sv
// Request/result bundle for leg_solver: start with two operands in,
// busy/done/err status and the computed leg out.
interface leg_solver_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] r_in;
  logic [WIDTH-1:0] x_in;
  logic             busy;
  logic             done;
  logic             err;
  logic [WIDTH-1:0] y_out;

  modport master (
    output start, r_in, x_in,
    input  busy, done, err, y_out
  );

  modport slave (
    input  start, r_in, x_in,
    output busy, done, err, y_out
  );
endinterface

// File: rtl/leg_solver.sv
// Computes y = floor(sqrt(r^2 - x^2)) with shift-add squaring and a restoring
// square root. Define LEG_ROUND_EN to round y to nearest instead of flooring.
module leg_solver #(
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  leg_solver_if.slave  bus
);

  localparam int DW = 2 * WIDTH;
  localparam int RW = WIDTH + 3;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SQ,
    S_SUB,
    S_ROOT,
    S_FIN
  } state_t;

  state_t state, state_nxt;

  logic [DW-1:0]    mcand_r, mcand_x;
  logic [WIDTH-1:0] mplr_r, mplr_x;
  logic [DW-1:0]    acc_r, acc_x;
  logic [WIDTH-1:0] q;
  logic [RW-1:0]    rem;
  logic [CW-1:0]    cnt;
  logic             err_flag;

  logic             last;
  logic [RW-1:0]    rem_sh;
  logic [RW-1:0]    trial;
  logic             fit;
  logic [WIDTH-1:0] q_final;

  assign last = (cnt == CW'(WIDTH - 1));

  // NOTE: state registers use <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // NOTE: defaults first so no path leaves state_nxt unassigned (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (bus.start) state_nxt = (bus.x_in > bus.r_in) ? S_FIN : S_SQ;
      S_SQ:   if (last) state_nxt = S_SUB;
      S_SUB:  state_nxt = S_ROOT;
      S_ROOT: if (last) state_nxt = S_FIN;
      S_FIN:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Root step: bring down the next two bits of D (held at the top of acc_r).
  always_comb begin
    rem_sh = {rem[RW-3:0], acc_r[DW-1 -: 2]};
    trial  = {1'b0, q, 2'b01};
    fit    = (rem_sh >= trial);
  end

`ifdef LEG_ROUND_EN
  // After the root loop rem holds D - q^2; above q means nearer to q+1.
  always_comb begin
    q_final = q;
    if (rem > {3'b000, q}) q_final = q + 1'b1;
  end
`else
  always_comb begin
    q_final = q;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_r   <= '0;
      mcand_x   <= '0;
      mplr_r    <= '0;
      mplr_x    <= '0;
      acc_r     <= '0;
      acc_x     <= '0;
      q         <= '0;
      rem       <= '0;
      cnt       <= '0;
      err_flag  <= 1'b0;
      bus.busy  <= 1'b0;
      bus.done  <= 1'b0;
      bus.err   <= 1'b0;
      bus.y_out <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            mcand_r  <= {{WIDTH{1'b0}}, bus.r_in};
            mcand_x  <= {{WIDTH{1'b0}}, bus.x_in};
            mplr_r   <= bus.r_in;
            mplr_x   <= bus.x_in;
            acc_r    <= '0;
            acc_x    <= '0;
            q        <= '0;
            rem      <= '0;
            cnt      <= '0;
            err_flag <= (bus.x_in > bus.r_in);
            bus.busy <= 1'b1;
          end
        end
        S_SQ: begin
          if (mplr_r[0]) acc_r <= acc_r + mcand_r;
          if (mplr_x[0]) acc_x <= acc_x + mcand_x;
          mcand_r <= mcand_r << 1;
          mcand_x <= mcand_x << 1;
          mplr_r  <= mplr_r >> 1;
          mplr_x  <= mplr_x >> 1;
          cnt     <= last ? '0 : cnt + 1'b1;
        end
        S_SUB: begin
          // x <= r was checked at accept, so the difference cannot wrap.
          acc_r <= acc_r - acc_x;
        end
        S_ROOT: begin
          acc_r <= acc_r << 2;
          rem   <= fit ? (rem_sh - trial) : rem_sh;
          q     <= {q[WIDTH-2:0], fit};
          cnt   <= last ? '0 : cnt + 1'b1;
        end
        S_FIN: begin
          bus.busy  <= 1'b0;
          bus.done  <= 1'b1;
          bus.err   <= err_flag;
          bus.y_out <= err_flag ? '0 : q_final;
        end
        default: ;
      endcase
    end
  end

endmodule
